// File: rtl/truth_table_checker_if.sv
// truth_table_checker_if
//   Bundles the stimulus/result signals of truth_table_checker.
//   Parameter N_IN : number of DUT inputs (2**N_IN vectors).
//   slave  modport : checker side (drives vec and the result flags).
//   master modport : bench/DUT side (drives start, expected, dut_o).
//   Signals:
//     start      begin a run (ignored while busy)
//     expected   truth table, expected[k] = required output for vector k
//     dut_o      output of the device under test
//     vec        vector applied to the DUT inputs
//     busy       run in progress
//     done       run finished, held until next start or reset
//     pass       valid with done, 1 = no mismatches
//     err_count  number of mismatching vectors
//     fail_valid at least one mismatch recorded
//     first_fail index of the first mismatching vector
interface truth_table_checker_if #(
    parameter int unsigned N_IN = 3
);
    logic                   start;
    logic [(1<<N_IN)-1:0]   expected;
    logic                   dut_o;
    logic [N_IN-1:0]        vec;
    logic                   busy;
    logic                   done;
    logic                   pass;
    logic [N_IN:0]          err_count;
    logic                   fail_valid;
    logic [N_IN-1:0]        first_fail;

    modport slave (
        input  start, expected, dut_o,
        output vec, busy, done, pass, err_count, fail_valid, first_fail
    );

    modport master (
        output start, expected, dut_o,
        input  vec, busy, done, pass, err_count, fail_valid, first_fail
    );
endinterface

// File: rtl/truth_table_checker.sv
// truth_table_checker
//   Exhaustive stimulus engine for an N_IN-input combinational DUT. Each
//   vector is held for DWELL cycles; the DUT output is sampled on the last
//   cycle of the dwell and compared against the supplied truth table.
//   Parameters : N_IN  (1..8) number of DUT inputs
//                DWELL (>=1)  cycles each vector is held
//   Ports      : clk   rising-edge clock
//                rst_n asynchronous active-low reset
//                bus   truth_table_checker_if.slave (start/expected/dut_o in,
//                      vec/busy/done/pass/err_count/fail_valid/first_fail out)
//   Build option: TTC_STOP_ON_FAIL_EN - when defined, the run ends on the
//                first mismatch with vec holding the failing vector.
module truth_table_checker #(
    parameter int unsigned N_IN  = 3,
    parameter int unsigned DWELL = 10
) (
    input  logic                    clk,
    input  logic                    rst_n,
    truth_table_checker_if.slave    bus
);

    localparam int unsigned DW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam int unsigned EW = N_IN + 1;

    typedef enum logic [1:0] {
        IDLE,
        APPLY,
        DONE
    } state_t;

    state_t            state_q;
    logic [N_IN-1:0]   vec_q;
    logic [DW-1:0]     dwell_q;
    logic [EW-1:0]     err_count_q;
    logic [EW-1:0]     err_count_d;
    logic              fail_valid_q;
    logic [N_IN-1:0]   first_fail_q;
    logic              busy_q;
    logic              done_q;
    logic              pass_q;

    logic              last_dwell;
    logic              last_vec;
    logic              mismatch;
    logic              stop_now;

    always_comb begin
        last_dwell  = (dwell_q == DW'(DWELL - 1));
        last_vec    = &vec_q;
        mismatch    = (bus.dut_o != bus.expected[vec_q]);
        err_count_d = err_count_q + EW'(mismatch);
`ifdef TTC_STOP_ON_FAIL_EN
        stop_now    = mismatch;
`else
        stop_now    = 1'b0;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            vec_q        <= '0;
            dwell_q      <= '0;
            err_count_q  <= '0;
            fail_valid_q <= 1'b0;
            first_fail_q <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (bus.start) begin
                        state_q      <= APPLY;
                        vec_q        <= '0;
                        dwell_q      <= '0;
                        err_count_q  <= '0;
                        fail_valid_q <= 1'b0;
                        first_fail_q <= '0;
                        busy_q       <= 1'b1;
                        done_q       <= 1'b0;
                        pass_q       <= 1'b0;
                    end
                end
                APPLY: begin
                    if (!last_dwell) begin
                        dwell_q <= dwell_q + DW'(1);
                    end else begin
                        err_count_q <= err_count_d;
                        if (mismatch && !fail_valid_q) begin
                            first_fail_q <= vec_q;
                            fail_valid_q <= 1'b1;
                        end
                        // pass uses err_count_d so the final comparison is included
                        if (stop_now || last_vec) begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            pass_q  <= (err_count_d == '0);
                        end else begin
                            vec_q   <= vec_q + N_IN'(1);
                            dwell_q <= '0;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.vec        = vec_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.pass       = pass_q;
    assign bus.err_count  = err_count_q;
    assign bus.fail_valid = fail_valid_q;
    assign bus.first_fail = first_fail_q;

endmodule

// File: tb/tb_truth_table_checker.sv
// tb_truth_table_checker
//   Two checker instances: A (N_IN=3, DWELL=10) and B (N_IN=4, DWELL=1).
//   Each DUT output is a lookup into a bench-owned table indexed by vec, so
//   any logic function (majority, stuck-at, random) can be emulated.
module tb_truth_table_checker;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;
    int   sel;

    logic [7:0]  tab_a;
    logic [15:0] tab_b;

    logic [31:0] o_vec, o_busy, o_done, o_pass, o_err, o_fv, o_ff;

    truth_table_checker_if #(.N_IN(3)) ifa ();
    truth_table_checker_if #(.N_IN(4)) ifb ();

    truth_table_checker #(.N_IN(3), .DWELL(10)) u_dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifa)
    );

    truth_table_checker #(.N_IN(4), .DWELL(1)) u_dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifb)
    );

    assign ifa.dut_o = tab_a[ifa.vec];
    assign ifb.dut_o = tab_b[ifb.vec];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        if (sel != 0) begin
            o_vec  = 32'(ifb.vec);
            o_busy = 32'(ifb.busy);
            o_done = 32'(ifb.done);
            o_pass = 32'(ifb.pass);
            o_err  = 32'(ifb.err_count);
            o_fv   = 32'(ifb.fail_valid);
            o_ff   = 32'(ifb.first_fail);
        end else begin
            o_vec  = 32'(ifa.vec);
            o_busy = 32'(ifa.busy);
            o_done = 32'(ifa.done);
            o_pass = 32'(ifa.pass);
            o_err  = 32'(ifa.err_count);
            o_fv   = 32'(ifa.fail_valid);
            o_ff   = 32'(ifa.first_fail);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s (inst %0d, t=%0t): got %0d expected %0d", tag, sel, $time, got, exp);
        end
    endtask

    task automatic set_start(input logic v);
        if (sel != 0) ifb.start = v;
        else          ifa.start = v;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_vec"},  o_vec,  0);
        check({tag, "_busy"}, o_busy, 0);
        check({tag, "_done"}, o_done, 0);
        check({tag, "_pass"}, o_pass, 0);
        check({tag, "_err"},  o_err,  0);
        check({tag, "_fv"},   o_fv,   0);
        check({tag, "_ff"},   o_ff,   0);
    endtask

    // Reference: the run is described purely by which table entries disagree.
    // A vector k has been judged once c >= (k+1)*DWELL cycles have elapsed.
    task automatic run_case(input int inst, input logic [15:0] exp_tab,
                            input logic [15:0] dut_tab, input int glitch_c,
                            input int rst_c);
        int n, d, nv, first, total, done_c, errm, stop;
        logic [15:0] mism;
        sel = inst;
        n   = (inst != 0) ? 4 : 3;
        d   = (inst != 0) ? 1 : 10;
        nv  = 1 << n;
        mism = (exp_tab ^ dut_tab) & ((inst != 0) ? 16'hFFFF : 16'h00FF);
        if (inst != 0) begin
            ifb.expected = exp_tab;
            tab_b        = dut_tab;
        end else begin
            ifa.expected = exp_tab[7:0];
            tab_a        = dut_tab[7:0];
        end
        first = -1;
        total = 0;
        for (int k = 0; k < nv; k++) begin
            if (mism[k]) begin
                total++;
                if (first < 0) first = k;
            end
        end
`ifdef TTC_STOP_ON_FAIL_EN
        stop = 1;
`else
        stop = 0;
`endif
        done_c = (stop != 0 && first >= 0) ? (first + 1) * d : nv * d;

        @(posedge clk); #1;
        set_start(1'b1);
        @(posedge clk); #1;
        set_start(1'b0);

        errm = 0;
        for (int c = 0; c <= done_c; c++) begin
            if (c > 0) begin
                @(posedge clk); #1;
            end
            errm = 0;
            for (int k = 0; k < nv; k++)
                if (mism[k] && (k + 1) * d <= c) errm++;
            if (c < done_c) begin
                check("run_vec",  o_vec,  32'(c / d));
                check("run_busy", o_busy, 1);
                check("run_done", o_done, 0);
                check("run_err",  o_err,  32'(errm));
                check("run_fv",   o_fv,   (errm > 0) ? 1 : 0);
                if (errm > 0) check("run_first_fail", o_ff, 32'(first));
                if (c == 0)   check("run_pass_clear", o_pass, 0);
            end else begin
                check("final_vec",  o_vec,  (stop != 0 && first >= 0) ? 32'(first) : 32'(nv - 1));
                check("final_busy", o_busy, 0);
                check("final_done", o_done, 1);
                check("final_err",  o_err,  32'(errm));
                check("final_pass", o_pass, (errm == 0) ? 1 : 0);
                check("final_fv",   o_fv,   (errm > 0) ? 1 : 0);
                check("final_ff",   o_ff,   (first >= 0) ? 32'(first) : 0);
            end
            if (c == glitch_c)          set_start(1'b1);
            else if (c == glitch_c + 1) set_start(1'b0);
            if (c == rst_c) begin
                rst_n = 1'b0;
                #1;
                check_all_zero("midrun_reset");
                #2;
                rst_n = 1'b1;
                return;
            end
        end
        set_start(1'b0);

        repeat (3) @(posedge clk);
        #1;
        check("hold_done", o_done, 1);
        check("hold_busy", o_busy, 0);
        check("hold_err",  o_err,  32'(errm));
    endtask

    initial begin
        logic [15:0] e, f;
        n_checks     = 0;
        n_errors     = 0;
        sel          = 0;
        tab_a        = '0;
        tab_b        = '0;
        ifa.start    = 1'b0;
        ifa.expected = '0;
        ifb.start    = 1'b0;
        ifb.expected = '0;
        rst_n        = 1'b0;

        #12;
        sel = 0; #1; check_all_zero("reset_a");
        sel = 1; #1; check_all_zero("reset_b");
        @(negedge clk);
        rst_n = 1'b1;

        // Golden: 3-input majority against its own truth table
        run_case(0, 16'h00E8, 16'h00E8, -10, -10);
        // Stuck-at-0 output: fails vectors 3,5,6,7; restarts straight from DONE
        run_case(0, 16'h00E8, 16'h0000, -10, -10);
        // start pulsed while busy must not disturb the run
        run_case(0, 16'h00E8, 16'h00FF, 25, -10);
        // Random tables, alternating matching and faulty DUTs
        for (int i = 0; i < 4; i++) begin
            e = 16'($urandom);
            f = (i % 2 == 0) ? e : (e ^ 16'($urandom));
            run_case(0, e, f, -10, -10);
        end
        // Reset in the middle of a run, then a clean run afterwards
        run_case(0, 16'h00E8, 16'h0011, -10, 33);
        sel = 0;
        @(posedge clk); #1;
        check_all_zero("post_reset_idle");
        run_case(0, 16'h00E8, 16'h00E8, -10, -10);

        // Fast sweep: one vector per cycle
        run_case(1, 16'hFFFF, 16'hFFFF, -10, -10);
        e = 16'($urandom);
        f = e ^ 16'($urandom);
        run_case(1, e, f, -10, -10);
        run_case(1, 16'h8001, 16'h0001, -10, -10);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete, got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
